// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, flush with bubble insertion, saturating stall counter.
// Optional build macro PIPE_STAGE_SKID_EN adds a skid entry and makes in_ready a registered signal.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, emit;

  assign emit   = main_valid_q && out_ready;
  assign accept = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  // Ready depends only on skid occupancy, so no combinational path from out_ready or flush.
  assign in_ready = !skid_valid_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (emit) begin
        main_data_d  = skid_data_q;
        main_ctrl_d  = skid_ctrl_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || emit) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_ctrl_d  = in_ctrl;
      end
    end else if (emit) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end
`else
  assign in_ready = out_ready || !main_valid_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data;
      main_ctrl_d  = in_ctrl;
    end else if (emit) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (main_valid_q && !out_ready && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      cnt_q        <= cnt_d;
    end
  end

  // Empty stage presents a bubble: control forced to zero, data left as-is.
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a queue-based reference model checked every cycle.
// Works for both the default and PIPE_STAGE_SKID_EN builds.
module tb_pipe_stage_reg;
  localparam int DW  = 32;
  localparam int CW  = 5;
  localparam int NW  = 4;
  localparam int SAT = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          flush = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [NW-1:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of held entries in acceptance order, capacity 1 or 2.
  logic [DW-1:0] mq_d[$];
  logic [CW-1:0] mq_c[$];
  int            m_cnt = 0;
  logic [DW-1:0] m_last = '0;

  function automatic bit m_ready();
`ifdef PIPE_STAGE_SKID_EN
    return mq_d.size() < 2;
`else
    return out_ready || (mq_d.size() == 0);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq_d.delete();
      mq_c.delete();
      m_cnt  = 0;
      m_last = '0;
    end else begin
      bit acc, emt;
      acc = in_valid && m_ready();
      emt = (mq_d.size() > 0) && out_ready;
      if (cnt_clr) m_cnt = 0;
      else if (mq_d.size() > 0 && !out_ready && m_cnt < SAT) m_cnt++;
      if (flush) begin
        mq_d.delete();
        mq_c.delete();
      end else begin
        if (emt) begin
          void'(mq_d.pop_front());
          void'(mq_c.pop_front());
        end
        if (acc) begin
          mq_d.push_back(in_data);
          mq_c.push_back(in_ctrl);
        end
      end
      if (mq_d.size() > 0) m_last = mq_d[0];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", out_valid, mq_d.size() > 0);
      chk("m_in_ready", in_ready, m_ready());
      chk("m_stall_cnt", stall_cnt, m_cnt);
      if (mq_d.size() > 0) begin
        chk("m_out_data", out_data, mq_d[0]);
        chk("m_out_ctrl", out_ctrl, mq_c[0]);
      end else begin
        chk("m_out_data_hold", out_data, m_last);
        chk("m_out_ctrl_bubble", out_ctrl, 0);
      end
    end
  end

  // Present one entry and hold it until an edge accepts it (bounded).
  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      done = in_ready;
      @(posedge clk);
      #2;
    end
    chk("send_accept_timeout", done, 1);
    in_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Stream at full rate
    out_ready = 1'b1;
    in_ctrl   = 5'b10011;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      cyc(1);
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, i);
      chk("stream_ctrl", out_ctrl, 5'b10011);
    end
    in_valid = 1'b0;
    cyc(1);
    chk("stream_drained", out_valid, 0);
    chk("stream_stall", stall_cnt, 0);

    // Back-pressure
    out_ready = 1'b0;
    send(32'hAAAA, 5'b00001);
`ifdef PIPE_STAGE_SKID_EN
    send(32'hBBBB, 5'b00010);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_head", out_data, 32'hAAAA);
    cyc(3);
    chk("bp_hold", out_data, 32'hAAAA);
    chk("bp_stall", stall_cnt, 4);
    out_ready = 1'b1;
    cyc(1);
    chk("bp_second", out_data, 32'hBBBB);
    chk("bp_in_ready_back", in_ready, 1);
`else
    in_valid = 1'b1;
    in_data  = 32'hBBBB;
    in_ctrl  = 5'b00010;
    #1;
    chk("bp_in_ready_low", in_ready, 0);
    cyc(3);
    chk("bp_hold", out_data, 32'hAAAA);
    chk("bp_stall", stall_cnt, 3);
    out_ready = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    chk("bp_second", out_data, 32'hBBBB);
    chk("bp_in_ready_back", in_ready, 1);
`endif
    cyc(1);
    chk("bp_drained", out_valid, 0);

    // Flush a full stage with a concurrent input
    out_ready = 1'b0;
    send(32'hE0, 5'b11111);
    in_valid  = 1'b1;
    in_data   = 32'hC;
    in_ctrl   = 5'b00100;
    flush     = 1'b1;
    out_ready = 1'b1;
    cyc(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ctrl", out_ctrl, 0);
    send(32'hD, 5'b01000);
    chk("flush_next_valid", out_valid, 1);
    chk("flush_next_data", out_data, 32'hD);
    cyc(1);

    // Bubble: control must not leak from an empty stage
    in_valid = 1'b0;
    in_ctrl  = '1;
    for (int k = 0; k < 6; k++) begin
      out_ready = k[0];
      cyc(1);
      chk("bubble_ctrl", out_ctrl, 0);
    end

    // Stall counter saturation and clear
    out_ready = 1'b0;
    send(32'h55, 5'b00010);
    cyc(20);
    chk("cnt_saturate", stall_cnt, SAT);
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    chk("cnt_clear", stall_cnt, 0);
    chk("cnt_still_full", out_valid, 1);

    // Asynchronous reset mid-cycle with the stage full
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ctrl", out_ctrl, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_stall", stall_cnt, 0);
    @(posedge clk);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(32'h77, 5'b00011);
    chk("post_rst_data", out_data, 32'h77);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
